pixel_wb_burst_sched: RTL
=========================

// Module: pixel_wb_burst_sched
// PURPOSE
// Write-back scheduler for decoded pixel output. Walks a 2-D framebuffer region (rows x words) and
// issues one address/length request per AXI write burst into the pixel AXI former's addr port.
// Tracks outstanding bursts via the B channel and signals frame completion once all data has drained.
// PARAMETERS
// MAX_BEATS    8   max beats per burst, legal 1..8 (len field is 3 bits)
// MAX_OUTST    4   max bursts issued but not yet acknowledged on B, legal 1..15
// W_BITS       16  width of row-length (words) config
// H_BITS       16  width of row-count config
// PORTS
// clk            in   1       clock
// rst_n          in   1       reset, synchronous, active-low
// start_i        in   1       frame start pulse; sampled only in IDLE
// base_addr_i    in   32      byte address of first word, 4-byte aligned
// stride_i       in   32      byte distance between row starts
// width_words_i  in   W_BITS  32-bit words per row
// height_i       in   H_BITS  number of rows
// busy_o         out  1       high from accepted start until done_o
// done_o         out  1       one-cycle completion pulse
// err_o          out  1       sticky: some B response != OKAY; cleared by next accepted start
// addr_valid_o   out  1       burst request valid (to former addr_valid_i)
// addr_ready_i   in   1       former accepts request
// addr_o         out  32      burst start byte address
// len_o          out  3       beats-1
// bvalid_i       in   1       AXI write response valid
// bready_o       out  1       AXI write response ready
// bresp_i        in   2       AXI write response code
// former_empty_i in   1       former has no queued addr/data
// flush_o        out  1       one-cycle flush pulse to former
// BEHAVIOUR
// - Reset: state IDLE; busy_o, done_o, err_o, addr_valid_o, flush_o = 0; addr_o, len_o = 0; counters 0.
// - States: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
// - IDLE: start_i latches base/stride/width/height; row_base=col=row=0-relative; err_o cleared.
//   width==0 or height==0 -> straight to DRAIN (no bursts). Otherwise -> ISSUE next cycle.
// - ISSUE: beats = min(width - col, MAX_BEATS); addr_o = row_base + col*4; len_o = beats-1.
//   addr_valid_o high iff outst < MAX_OUTST. addr_o/len_o stable while valid && !ready.
//   On handshake: col += beats; if col reaches width: col=0, row_base += stride, row++.
//   After last row's last burst handshakes -> DRAIN. Address arithmetic wraps mod 2^32.
// - outst counter: +1 on addr handshake, -1 on bvalid_i && bready_o; both same cycle -> unchanged.
// - bready_o = 1 in every state except IDLE; B beats in IDLE are not consumed.
// - DRAIN: wait until outst==0 && former_empty_i -> DONE. DONE: done_o=1 one cycle, busy_o drops
//   same cycle as done_o deasserts (busy_o low in following IDLE) -> IDLE.
// - err_o set on any accepted B with bresp_i != 2'b00; stays set until next accepted start.
// - start_i while busy ignored. rst_n low mid-frame: immediate IDLE, no done_o, no flush_o.
// - Throughput: one request per cycle when addr_ready_i and outst < MAX_OUTST.
// CONFIGURATION
// PIX_WB_ERR_ABORT_EN defined: on first error B in ISSUE/DRAIN, stop issuing (addr_valid_o=0 next
//   cycle), pulse flush_o for one cycle, wait outst==0 (remaining B still accepted and counted),
//   then DONE with err_o=1. former_empty_i ignored after flush.
// Not defined: errors only set err_o; frame completes normally; flush_o tied 0.
// TESTING
// T1 base=0x1000, stride=0x100, width=20, height=2, ready=1, B returned 2 cycles later ->
//    requests (0x1000,7)(0x1020,7)(0x1040,3)(0x1100,7)(0x1120,7)(0x1140,3); one done_o; err_o=0.
// T2 width=3, height=1, B withheld -> one request len=2; no done_o until B arrives and
//    former_empty_i=1; done_o exactly one cycle after both hold plus DRAIN->DONE.
// T3 MAX_OUTST=4, width=64, height=1, bvalid_i=0 -> exactly 4 requests then addr_valid_o=0;
//    one B releases exactly one further request.
// T4 addr_ready_i low 5 cycles on 2nd request -> addr_o/len_o held constant; no duplicate/skip.
// T5 width=0 or height=0 -> no requests, done_o pulses; start_i during busy frame -> ignored.
// T6 bresp=2'b10 on 1st B: without macro all 6 T1 bursts issue, err_o=1 at done; with
//    PIX_WB_ERR_ABORT_EN no further requests, one flush_o pulse, done_o after outst==0, err_o=1.

Source files
------------

// File: rtl/pixel_wb_burst_sched.sv
// pixel_wb_burst_sched: walks a rows x words framebuffer region issuing one AXI write-burst request per burst.
// Optional PIX_WB_ERR_ABORT_EN: abort and flush the former on the first error response.
module pixel_wb_burst_sched #(
    parameter int MAX_BEATS = 8,
    parameter int MAX_OUTST = 4,
    parameter int W_BITS    = 16,
    parameter int H_BITS    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [31:0]       base_addr_i,
    input  logic [31:0]       stride_i,
    input  logic [W_BITS-1:0] width_words_i,
    input  logic [H_BITS-1:0] height_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              addr_valid_o,
    input  logic              addr_ready_i,
    output logic [31:0]       addr_o,
    output logic [2:0]        len_o,
    input  logic              bvalid_i,
    output logic              bready_o,
    input  logic [1:0]        bresp_i,
    input  logic              former_empty_i,
    output logic              flush_o
);
    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, DONE, ABORT} state_t;
    localparam logic [3:0] MO = 4'(MAX_OUTST);
    localparam logic [W_BITS-1:0] MB = W_BITS'(MAX_BEATS);

    state_t            state;
    logic [31:0]       stride, row_base, nxt_base;
    logic [W_BITS-1:0] width, col, col_adv, nxt_col, nxt_rem, nxt_beats, first_beats;
    logic [H_BITS-1:0] height, row;
    logic [3:0]        outst, outst_n;
    logic              hs, bacc, row_end, last;

    // Next burst is derived from the one currently offered, so addr_o/len_o stay registered.
    always_comb begin
        hs          = addr_valid_o && addr_ready_i;
        bacc        = bvalid_i && bready_o;
        outst_n     = outst + 4'(hs) - 4'(bacc);
        col_adv     = col + W_BITS'(len_o) + W_BITS'(1);
        row_end     = col_adv >= width;
        last        = row_end && (row + H_BITS'(1) == height);
        nxt_col     = row_end ? '0 : col_adv;
        nxt_base    = row_end ? row_base + stride : row_base;
        nxt_rem     = width - nxt_col;
        nxt_beats   = nxt_rem > MB ? MB : nxt_rem;
        first_beats = width_words_i > MB ? MB : width_words_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            addr_valid_o <= 1'b0;
            bready_o     <= 1'b0;
            flush_o      <= 1'b0;
            addr_o       <= '0;
            len_o        <= '0;
            stride       <= '0;
            row_base     <= '0;
            width        <= '0;
            height       <= '0;
            col          <= '0;
            row          <= '0;
            outst        <= '0;
        end else begin
            outst <= outst_n;
            if (bacc && bresp_i != 2'b00) err_o <= 1'b1;
            case (state)
                IDLE: if (start_i) begin
                    width    <= width_words_i;
                    height   <= height_i;
                    stride   <= stride_i;
                    row_base <= base_addr_i;
                    col      <= '0;
                    row      <= '0;
                    err_o    <= 1'b0;
                    busy_o   <= 1'b1;
                    bready_o <= 1'b1;
                    addr_o   <= base_addr_i;
                    len_o    <= 3'(first_beats - W_BITS'(1));
                    if (width_words_i == '0 || height_i == '0) state <= DRAIN;
                    else begin
                        state        <= ISSUE;
                        addr_valid_o <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (hs) begin
                        col      <= nxt_col;
                        row_base <= nxt_base;
                        row      <= row_end ? row + H_BITS'(1) : row;
                        addr_o   <= nxt_base + (32'(nxt_col) << 2);
                        len_o    <= 3'(nxt_beats - W_BITS'(1));
                    end
                    if (hs && last) begin
                        state        <= DRAIN;
                        addr_valid_o <= 1'b0;
                    end else addr_valid_o <= outst_n < MO;
                end
                DRAIN: if (outst == '0 && former_empty_i) begin
                    state  <= DONE;
                    done_o <= 1'b1;
                end
                DONE: begin
                    state    <= IDLE;
                    done_o   <= 1'b0;
                    busy_o   <= 1'b0;
                    bready_o <= 1'b0;
                end
                ABORT: begin
                    flush_o <= 1'b0;
                    if (outst == '0) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef PIX_WB_ERR_ABORT_EN
            if ((state == ISSUE || state == DRAIN) && bacc && bresp_i != 2'b00 && !err_o) begin
                state        <= ABORT;
                addr_valid_o <= 1'b0;
                flush_o      <= 1'b1;
            end
`else
            flush_o <= 1'b0;
`endif
        end
    end
endmodule
